// File: rtl/ula_arbiter.sv
// Two-requester round-robin front end for a shared 16-bit ULA (add/or/and/not + equality flag).
// One transaction in flight: IDLE accepts, EXEC computes, RESP holds the result until taken.
module ula_arbiter #(
    parameter int WIDTH     = 16,
    parameter int CNT_WIDTH = 8
) (
    input  logic                 clock,
    input  logic                 reset,

    input  logic                 req0Valid,
    output logic                 req0Ready,
    input  logic [1:0]           req0Control,
    input  logic [WIDTH-1:0]     req0OpA,
    input  logic [WIDTH-1:0]     req0OpB,
    output logic                 rsp0Valid,
    input  logic                 rsp0Ready,
    output logic [WIDTH-1:0]     rsp0Result,
    output logic                 rsp0Zero,

    input  logic                 req1Valid,
    output logic                 req1Ready,
    input  logic [1:0]           req1Control,
    input  logic [WIDTH-1:0]     req1OpA,
    input  logic [WIDTH-1:0]     req1OpB,
    output logic                 rsp1Valid,
    input  logic                 rsp1Ready,
    output logic [WIDTH-1:0]     rsp1Result,
    output logic                 rsp1Zero,

    output logic                 busy,
    output logic [CNT_WIDTH-1:0] conflictCount
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_RESP = 2'b10
    } state_t;

    localparam logic [1:0]           OP_ADD  = 2'b00;
    localparam logic [1:0]           OP_OR   = 2'b01;
    localparam logic [1:0]           OP_AND  = 2'b10;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    state_t                 state_reg, state_next;
    logic                   last_grant_reg, last_grant_next;
    logic                   grant_id_reg, grant_id_next;
    logic [1:0]             ctrl_reg, ctrl_next;
    logic [WIDTH-1:0]       opa_reg, opa_next;
    logic [WIDTH-1:0]       opb_reg, opb_next;
    logic [WIDTH-1:0]       result_reg, result_next;
    logic                   zero_reg, zero_next;
    logic [CNT_WIDTH-1:0]   conflict_reg, conflict_next;

    logic [1:0]             req_valid;
    logic [1:0]             req_ready;
    logic [1:0]             rsp_ready;
    logic [1:0]             rsp_valid;
    logic                   any_valid;
    logic                   both_valid;
    logic                   winner;
    logic [1:0]             sel_ctrl;
    logic [WIDTH-1:0]       sel_opa;
    logic [WIDTH-1:0]       sel_opb;
    logic [WIDTH-1:0]       alu_result;

    assign req_valid  = {req1Valid, req0Valid};
    assign rsp_ready  = {rsp1Ready, rsp0Ready};
    assign any_valid  = |req_valid;
    assign both_valid = &req_valid;

    // On a tie the requester that did not win last time goes first.
    always_comb begin
        winner = 1'b0;
        if (both_valid) begin
            winner = ~last_grant_reg;
        end else if (req_valid[1]) begin
            winner = 1'b1;
        end
    end

    assign sel_ctrl = winner ? req1Control : req0Control;
    assign sel_opa  = winner ? req1OpA     : req0OpA;
    assign sel_opb  = winner ? req1OpB     : req0OpB;

    // Ready is gated by reset so a held request is never acknowledged while in reset.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_chan
            localparam logic CHAN_ID = 1'(gi);
            assign req_ready[gi] = reset && (state_reg == ST_IDLE) &&
                                   req_valid[gi] && (winner == CHAN_ID);
            assign rsp_valid[gi] = reset && (state_reg == ST_RESP) &&
                                   (grant_id_reg == CHAN_ID);
        end
    endgenerate

    assign req0Ready     = req_ready[0];
    assign req1Ready     = req_ready[1];
    assign rsp0Valid     = rsp_valid[0];
    assign rsp1Valid     = rsp_valid[1];
    assign rsp0Result    = result_reg;
    assign rsp1Result    = result_reg;
    assign rsp0Zero      = zero_reg;
    assign rsp1Zero      = zero_reg;
    assign busy          = (state_reg == ST_EXEC) || (state_reg == ST_RESP);
    assign conflictCount = conflict_reg;

    always_comb begin
        unique case (ctrl_reg)
            OP_ADD:  alu_result = opa_reg + opb_reg;
            OP_OR:   alu_result = opa_reg | opb_reg;
            OP_AND:  alu_result = opa_reg & opb_reg;
            default: alu_result = ~opa_reg;
        endcase
    end

    always_comb begin
        state_next      = state_reg;
        last_grant_next = last_grant_reg;
        grant_id_next   = grant_id_reg;
        ctrl_next       = ctrl_reg;
        opa_next        = opa_reg;
        opb_next        = opb_reg;
        result_next     = result_reg;
        zero_next       = zero_reg;
        conflict_next   = conflict_reg;

        if ((state_reg == ST_IDLE) && both_valid && (conflict_reg != '1)) begin
            conflict_next = conflict_reg + CNT_ONE;
        end

        case (state_reg)
            ST_IDLE: begin
                if (any_valid) begin
                    grant_id_next = winner;
                    ctrl_next     = sel_ctrl;
                    opa_next      = sel_opa;
                    opb_next      = sel_opb;
                    state_next    = ST_EXEC;
                end
            end
            ST_EXEC: begin
                result_next = alu_result;
                zero_next   = (opa_reg == opb_reg);
                state_next  = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready[grant_id_reg]) begin
                    last_grant_next = grant_id_reg;
                    state_next      = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg      <= ST_IDLE;
            last_grant_reg <= 1'b1;
            grant_id_reg   <= 1'b0;
            ctrl_reg       <= '0;
            opa_reg        <= '0;
            opb_reg        <= '0;
            result_reg     <= '0;
            zero_reg       <= 1'b0;
            conflict_reg   <= '0;
        end else begin
            state_reg      <= state_next;
            last_grant_reg <= last_grant_next;
            grant_id_reg   <= grant_id_next;
            ctrl_reg       <= ctrl_next;
            opa_reg        <= opa_next;
            opb_reg        <= opb_next;
            result_reg     <= result_next;
            zero_reg       <= zero_next;
            conflict_reg   <= conflict_next;
        end
    end

endmodule
